// File: rtl/blood_anim_ctrl.sv
// blood_anim_ctrl: sequences the blood-splatter sprite frames and gates ROM colour into an overlay pixel; define RETRIGGER_EN to let a trigger restart a running animation
module blood_anim_ctrl #(
  parameter int          NUM_FRAMES      = 16,
  parameter int          TICKS_PER_FRAME = 3,
  parameter logic [11:0] TRANSPARENT     = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [9:0]  hit_x,
  input  logic [9:0]  hit_y,
  input  logic        frame_tick,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [11:0] rom_color,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  output logic [3:0]  frame_sel,
  output logic        busy,
  output logic        done,
  output logic        blood_on,
  output logic [11:0] blood_rgb
);
  localparam int TW = TICKS_PER_FRAME > 1 ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICKS_PER_FRAME - 1);
  localparam logic [3:0] FLAST = 4'(NUM_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t state;
  logic [TW-1:0] tick_cnt;
  logic [9:0] org_x, org_y, dx, dy;
  logic in_box, in_box_d, show;
  assign dx = pix_x - org_x;
  assign dy = pix_y - org_y;
  assign rom_col = dx[5:0];
  assign rom_row = dy[5:0];
  // box bounds use 11-bit sums so a sprite at the screen edge clips instead of wrapping
  assign in_box = busy
    && ({1'b0, pix_x} >= {1'b0, org_x}) && ({1'b0, pix_x} < {1'b0, org_x} + 11'd64)
    && ({1'b0, pix_y} >= {1'b0, org_y}) && ({1'b0, pix_y} < {1'b0, org_y} + 11'd64);
  assign show = in_box_d && (rom_color != TRANSPARENT);
  // animation FSM plus the two-stage overlay pipeline; leaving PLAY flushes the pipeline
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      frame_sel <= '0;
      tick_cnt  <= '0;
      org_x     <= '0;
      org_y     <= '0;
      in_box_d  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      blood_on  <= 1'b0;
      blood_rgb <= '0;
    end else begin
      done      <= 1'b0;
      in_box_d  <= in_box;
      blood_on  <= show;
      blood_rgb <= show ? rom_color : '0;
      case (state)
        IDLE:
          if (trigger) begin
            state     <= PLAY;
            busy      <= 1'b1;
            org_x     <= hit_x;
            org_y     <= hit_y;
            frame_sel <= '0;
            tick_cnt  <= '0;
          end
        PLAY:
`ifdef RETRIGGER_EN
          if (trigger) begin
            org_x     <= hit_x;
            org_y     <= hit_y;
            frame_sel <= '0;
            tick_cnt  <= '0;
          end else if (frame_tick) begin
`else
          if (frame_tick) begin
`endif
            if (tick_cnt != TLAST) tick_cnt <= tick_cnt + 1'b1;
            else begin
              tick_cnt <= '0;
              if (frame_sel != FLAST) frame_sel <= frame_sel + 1'b1;
              else begin
                state     <= DONE;
                busy      <= 1'b0;
                done      <= 1'b1;
                frame_sel <= '0;
                in_box_d  <= 1'b0;
                blood_on  <= 1'b0;
                blood_rgb <= '0;
              end
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_blood_anim_ctrl.sv
// tb_blood_anim_ctrl: directed scenarios for the blood animation controller
module tb_blood_anim_ctrl;
  logic clk = 1'b0;
  logic reset, trigger, frame_tick;
  logic [9:0] hit_x, hit_y, pix_x, pix_y;
  logic [11:0] rom_color, blood_rgb;
  logic [5:0] rom_row, rom_col;
  logic [3:0] frame_sel;
  logic busy, done, blood_on;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  blood_anim_ctrl dut (
    .clk(clk), .reset(reset), .trigger(trigger), .hit_x(hit_x), .hit_y(hit_y),
    .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y), .rom_color(rom_color),
    .rom_row(rom_row), .rom_col(rom_col), .frame_sel(frame_sel), .busy(busy),
    .done(done), .blood_on(blood_on), .blood_rgb(blood_rgb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_trigger(input logic [9:0] x, input logic [9:0] y);
    hit_x = x;
    hit_y = y;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic show_pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
    pix_x = x;
    pix_y = y;
    rom_color = c;
    step();
    step();
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1; trigger = 0; frame_tick = 0; hit_x = 0; hit_y = 0;
    pix_x = 0; pix_y = 0; rom_color = 0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (frame_sel !== 4'd0) begin bad++; $display("FAIL reset_frame got=%0d exp=0", frame_sel); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (blood_on !== 1'b0) begin bad++; $display("FAIL reset_on got=%0b exp=0", blood_on); end
    total++; if (blood_rgb !== 12'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=000", blood_rgb); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      frame_tick = (i % 10 == 0);
      step();
      if (done !== 1'b0 || blood_on !== 1'b0) seen++;
    end
    frame_tick = 0;
    total++; if (seen !== 0) begin bad++; $display("FAIL idle_quiet got=%0d exp=0", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    total++; if (frame_sel !== 4'd0) begin bad++; $display("FAIL idle_frame got=%0d exp=0", frame_sel); end
  endtask

  task automatic test_play();
    hit_x = 100; hit_y = 50;
    trigger = 1'b1; frame_tick = 1'b1;
    step();
    trigger = 1'b0; frame_tick = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL play_busy got=%0b exp=1", busy); end
    total++; if (frame_sel !== 4'd0) begin bad++; $display("FAIL play_start got=%0d exp=0", frame_sel); end
    for (int k = 1; k <= 47; k++) begin
      tick();
      total++;
      if (frame_sel !== 4'(k / 3) || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL play_tick%0d got frame=%0d done=%0b busy=%0b exp frame=%0d done=0 busy=1",
                 k, frame_sel, done, busy, k / 3);
      end
    end
    tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL play_done got=%0b exp=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL play_busyfall got=%0b exp=0", busy); end
    total++; if (frame_sel !== 4'd0) begin bad++; $display("FAIL play_endframe got=%0d exp=0", frame_sel); end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_width got=%0b exp=0", done); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL done_trig_ignored got=%0b exp=0", busy); end
  endtask

  typedef struct {logic [9:0] x; logic [9:0] y; logic [11:0] c; logic on;} vec_t;

  task automatic test_pixel();
    vec_t v[5];
    v = '{'{10'd163, 10'd113, 12'h0AB, 1'b1}, '{10'd164, 10'd60, 12'hE00, 1'b0},
          '{10'd99, 10'd60, 12'hE00, 1'b0}, '{10'd110, 10'd114, 12'hE00, 1'b0},
          '{10'd100, 10'd50, 12'h123, 1'b1}};
    pulse_trigger(100, 50);
    pix_x = 110; pix_y = 60; rom_color = 12'hE00;
    #1;
    total++; if (rom_row !== 6'd10) begin bad++; $display("FAIL pix_row got=%0d exp=10", rom_row); end
    total++; if (rom_col !== 6'd10) begin bad++; $display("FAIL pix_col got=%0d exp=10", rom_col); end
    step(); step();
    total++; if (blood_on !== 1'b1) begin bad++; $display("FAIL pix_on got=%0b exp=1", blood_on); end
    total++; if (blood_rgb !== 12'hE00) begin bad++; $display("FAIL pix_rgb got=%h exp=e00", blood_rgb); end
    show_pix(110, 60, 12'h000);
    total++; if (blood_on !== 1'b0 || blood_rgb !== 12'h0) begin
      bad++; $display("FAIL pix_transp got on=%0b rgb=%h exp on=0 rgb=000", blood_on, blood_rgb);
    end
    for (int i = 0; i < 5; i++) begin
      show_pix(v[i].x, v[i].y, v[i].c);
      total++;
      if (blood_on !== v[i].on || blood_rgb !== (v[i].on ? v[i].c : 12'h0)) begin
        bad++;
        $display("FAIL pix_vec%0d got on=%0b rgb=%h exp on=%0b rgb=%h",
                 i, blood_on, blood_rgb, v[i].on, v[i].on ? v[i].c : 12'h0);
      end
    end
    do_reset();
  endtask

  task automatic test_edge();
    pulse_trigger(600, 450);
    pix_x = 639; pix_y = 479; rom_color = 12'h0F0;
    #1;
    total++; if (rom_col !== 6'd39) begin bad++; $display("FAIL edge_col got=%0d exp=39", rom_col); end
    total++; if (rom_row !== 6'd29) begin bad++; $display("FAIL edge_row got=%0d exp=29", rom_row); end
    step(); step();
    total++; if (blood_on !== 1'b1 || blood_rgb !== 12'h0F0) begin
      bad++; $display("FAIL edge_on got on=%0b rgb=%h exp on=1 rgb=0f0", blood_on, blood_rgb);
    end
    show_pix(10, 10, 12'h0F0);
    total++; if (blood_on !== 1'b0) begin bad++; $display("FAIL edge_nowrap got=%0b exp=0", blood_on); end
    do_reset();
    pulse_trigger(1000, 1000);
    show_pix(1010, 1010, 12'h555);
    total++; if (blood_on !== 1'b1 || blood_rgb !== 12'h555) begin
      bad++; $display("FAIL edge_11bit got on=%0b rgb=%h exp on=1 rgb=555", blood_on, blood_rgb);
    end
    total++; if (rom_col !== 6'd10) begin bad++; $display("FAIL edge_11bit_col got=%0d exp=10", rom_col); end
    do_reset();
  endtask

  task automatic test_retrigger();
    logic [3:0] f_now, f_later;
    logic [5:0] c_exp, r_exp;
`ifdef RETRIGGER_EN
    f_now = 0; f_later = 0; c_exp = 5; r_exp = 5;
`else
    f_now = 7; f_later = 8; c_exp = 41; r_exp = 55;
`endif
    pulse_trigger(100, 50);
    for (int k = 0; k < 21; k++) tick();
    total++; if (frame_sel !== 4'd7) begin bad++; $display("FAIL retrig_pre got=%0d exp=7", frame_sel); end
    hit_x = 200; hit_y = 100;
    trigger = 1'b1; frame_tick = 1'b1;
    step();
    trigger = 1'b0; frame_tick = 1'b0;
    total++; if (frame_sel !== f_now || done !== 1'b0) begin
      bad++; $display("FAIL retrig_frame got frame=%0d done=%0b exp frame=%0d done=0", frame_sel, done, f_now);
    end
    pix_x = 205; pix_y = 105;
    #1;
    total++; if (rom_col !== c_exp || rom_row !== r_exp) begin
      bad++; $display("FAIL retrig_origin got col=%0d row=%0d exp col=%0d row=%0d", rom_col, rom_row, c_exp, r_exp);
    end
    tick(); tick();
    total++; if (frame_sel !== f_later || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL retrig_after got frame=%0d done=%0b busy=%0b exp frame=%0d done=0 busy=1",
                      frame_sel, done, busy, f_later);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int seen;
    pulse_trigger(100, 50);
    pix_x = 120; pix_y = 70; rom_color = 12'h0F0;
    for (int k = 0; k < 15; k++) tick();
    total++; if (frame_sel !== 4'd5 || blood_on !== 1'b1) begin
      bad++; $display("FAIL mid_pre got frame=%0d on=%0b exp frame=5 on=1", frame_sel, blood_on);
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (busy !== 0 || frame_sel !== 0 || done !== 0 || blood_on !== 0 || blood_rgb !== 0) begin
      bad++; $display("FAIL mid_async got busy=%0b frame=%0d done=%0b on=%0b rgb=%h exp all 0",
                      busy, frame_sel, done, blood_on, blood_rgb);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done !== 1'b0) seen++;
    end
    reset = 1'b0;
    step();
    if (done !== 1'b0) seen++;
    total++; if (seen !== 0) begin bad++; $display("FAIL mid_nodone got=%0d exp=0", seen); end
    pulse_trigger(300, 300);
    total++; if (busy !== 1'b1 || frame_sel !== 4'd0) begin
      bad++; $display("FAIL mid_restart got busy=%0b frame=%0d exp busy=1 frame=0", busy, frame_sel);
    end
    tick(); tick(); tick();
    total++; if (frame_sel !== 4'd1) begin bad++; $display("FAIL mid_advance got=%0d exp=1", frame_sel); end
  endtask

  initial begin
    test_reset();
    test_play();
    test_pixel();
    test_edge();
    test_retrigger();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
